// File: rtl/reorder_buffer.sv
// ----------------------------------------------------------------------------
// reorder_buffer
//
// In-order retirement queue for the out-of-order RV32I core.
//   * Allocates one entry per issued instruction at the tail and reports the
//     index that the next issue will receive.
//   * Captures result broadcasts from the ALU reservation station (rs*) and
//     the load/store buffer (lsb*).
//   * Retires the head entry in program order. REG commits write the register
//     file, STORE commits release the store to memory, BRANCH commits check
//     the prediction and flush on a mispredict, and HALT stops retirement.
//   * Answers two combinational operand queries from the issue unit. A result
//     being broadcast in the same cycle is forwarded.
//
// Parameters
//   ROB_WIDTH  log2 of the entry count (SIZE = 2**ROB_WIDTH)
//   REG_WIDTH  architectural register index width
//
// Ports
//   clockIn, resetIn                  clock, synchronous active-high reset
//   issue*                            allocation request and entry contents
//   issueRobIndex, full               tail index; count >= SIZE-1
//   rsUpdate/rsRobIndex/rsVal         ALU result broadcast
//   lsbUpdate/lsbRobIndex/lsbVal      load value / store-address-ready broadcast
//   query{1,2}Index/Ready/Val         operand lookup with broadcast forwarding
//   commit*                           registered one-cycle retirement pulse
//   flush, flushPc                    registered mispredict pulse and target
//   halt                              sticky once a HALT entry retires
//
// Optional build feature
//   ROB_PERF_CNT_EN  adds perfCommits / perfFlushes, free-running 32-bit counts
//                    of commitValid and flush pulses, cleared by reset.
// ----------------------------------------------------------------------------
module reorder_buffer #(
    parameter int ROB_WIDTH = 4,
    parameter int REG_WIDTH = 5
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    // issue
    input  logic                 issueValid,
    input  logic [1:0]           issueType,
    input  logic [REG_WIDTH-1:0] issueRd,
    input  logic                 issueReady,
    input  logic [31:0]          issueVal,
    input  logic                 issuePredTaken,
    input  logic [31:0]          issueAltPc,
    output logic [ROB_WIDTH-1:0] issueRobIndex,
    output logic                 full,
    // result broadcasts
    input  logic                 rsUpdate,
    input  logic [ROB_WIDTH-1:0] rsRobIndex,
    input  logic [31:0]          rsVal,
    input  logic                 lsbUpdate,
    input  logic [ROB_WIDTH-1:0] lsbRobIndex,
    input  logic [31:0]          lsbVal,
    // operand queries
    input  logic [ROB_WIDTH-1:0] query1Index,
    input  logic [ROB_WIDTH-1:0] query2Index,
    output logic                 query1Ready,
    output logic                 query2Ready,
    output logic [31:0]          query1Val,
    output logic [31:0]          query2Val,
    // retirement
    output logic                 commitValid,
    output logic [ROB_WIDTH-1:0] commitRobIndex,
    output logic [REG_WIDTH-1:0] commitRd,
    output logic [31:0]          commitVal,
    output logic                 commitWrite,
    output logic                 commitStore,
    output logic                 flush,
    output logic [31:0]          flushPc,
    output logic                 halt
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]          perfCommits,
    output logic [31:0]          perfFlushes
`endif
);

    localparam int SIZE = 1 << ROB_WIDTH;

    localparam logic [1:0] TYPE_REG    = 2'b00;
    localparam logic [1:0] TYPE_STORE  = 2'b01;
    localparam logic [1:0] TYPE_BRANCH = 2'b10;
    localparam logic [1:0] TYPE_HALT   = 2'b11;

    // count is one bit wider than the pointers so that a completely full
    // buffer (count == SIZE) is distinguishable from an empty one.
    localparam logic [ROB_WIDTH:0] COUNT_MAX = {1'b1, {ROB_WIDTH{1'b0}}};
    localparam logic [ROB_WIDTH:0] FULL_MARK = COUNT_MAX - 1'b1;

    // ------------------------------------------------------------------------
    // Pointer state
    // ------------------------------------------------------------------------
    logic [ROB_WIDTH-1:0] head_q, head_d;
    logic [ROB_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_WIDTH:0]   count_q, count_d;

    // Per-entry contents, gathered from the per-entry registers below
    logic                 entry_valid [SIZE];
    logic                 entry_ready [SIZE];
    logic [1:0]           entry_type  [SIZE];
    logic [REG_WIDTH-1:0] entry_rd    [SIZE];
    logic [31:0]          entry_val   [SIZE];
    logic                 entry_pred  [SIZE];
    logic [31:0]          entry_alt   [SIZE];

    // Output registers
    logic                 commit_valid_q;
    logic [ROB_WIDTH-1:0] commit_idx_q;
    logic [REG_WIDTH-1:0] commit_rd_q;
    logic [31:0]          commit_val_q;
    logic                 commit_write_q;
    logic                 commit_store_q;
    logic                 flush_q;
    logic [31:0]          flush_pc_q;
    logic                 halt_q;

    // ------------------------------------------------------------------------
    // Retirement / allocation decisions
    // ------------------------------------------------------------------------
    logic        issue_accept;
    logic        commit_fire;
    logic        mispredict;
    logic [1:0]  head_type;
    logic [31:0] head_val;

    assign head_type = entry_type[head_q];
    assign head_val  = entry_val[head_q];

    // Allocation is refused only when every slot is occupied; full is an
    // early warning that leaves one slot for an issue unit reacting late.
    assign issue_accept = issueValid && (count_q != COUNT_MAX);

    // Retirement uses the stored ready bit only, so a broadcast takes one
    // edge to land in the entry and a second edge to appear as a commit.
    assign commit_fire = !halt_q && entry_valid[head_q] && entry_ready[head_q];

    // Bit 0 of a branch result is the resolved direction.
    assign mispredict = commit_fire && (head_type == TYPE_BRANCH) &&
                        (head_val[0] != entry_pred[head_q]);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (mispredict) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (commit_fire) begin
                head_d = head_q + 1'b1;
            end
            if (issue_accept) begin
                tail_d = tail_q + 1'b1;
            end
            case ({issue_accept, commit_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign issueRobIndex = tail_q;
    assign full          = (count_q >= FULL_MARK);

    // ------------------------------------------------------------------------
    // Entry storage: each slot decodes its own issue / update / retire hits.
    // valid and ready need a bulk clear on flush, so they live in flops.
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_entry
            localparam logic [ROB_WIDTH-1:0] ENTRY_IDX = ROB_WIDTH'(gi);

            logic                 valid_q;
            logic                 ready_q;
            logic [1:0]           type_q;
            logic [REG_WIDTH-1:0] rd_q;
            logic [31:0]          val_q;
            logic                 pred_q;
            logic [31:0]          alt_q;

            logic issue_hit;
            logic rs_hit;
            logic lsb_hit;
            logic retire_hit;

            assign issue_hit  = issue_accept && (tail_q == ENTRY_IDX);
            assign rs_hit     = rsUpdate  && valid_q && (rsRobIndex  == ENTRY_IDX);
            assign lsb_hit    = lsbUpdate && valid_q && (lsbRobIndex == ENTRY_IDX);
            assign retire_hit = commit_fire && (head_q == ENTRY_IDX);

            always_ff @(posedge clockIn) begin
                if (resetIn || mispredict) begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b0;
                end else begin
                    if (issue_hit) begin
                        valid_q <= 1'b1;
                        ready_q <= issueReady;
                    end else if (rs_hit || lsb_hit) begin
                        ready_q <= 1'b1;
                    end
                    // The retiring slot is released even if a broadcast
                    // also targets it this cycle.
                    if (retire_hit) begin
                        valid_q <= 1'b0;
                    end
                end
            end

            // Payload needs no reset: it is only observed while valid_q is set.
            always_ff @(posedge clockIn) begin
                if (!resetIn && !mispredict) begin
                    if (issue_hit) begin
                        type_q <= issueType;
                        rd_q   <= issueRd;
                        val_q  <= issueVal;
                        pred_q <= issuePredTaken;
                        alt_q  <= issueAltPc;
                    end else if (rs_hit) begin
                        // rs takes precedence when both broadcasts hit this slot
                        val_q <= rsVal;
                    end else if (lsb_hit && (type_q != TYPE_STORE)) begin
                        // A store only needs its ready bit; the lsb value is
                        // meaningless for it.
                        val_q <= lsbVal;
                    end
                end
            end

            assign entry_valid[gi] = valid_q;
            assign entry_ready[gi] = ready_q;
            assign entry_type[gi]  = type_q;
            assign entry_rd[gi]    = rd_q;
            assign entry_val[gi]   = val_q;
            assign entry_pred[gi]  = pred_q;
            assign entry_alt[gi]   = alt_q;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Operand queries: forward same-cycle broadcasts (rs before lsb), else
    // return the stored state. Unallocated entries never report ready.
    // ------------------------------------------------------------------------
    logic [ROB_WIDTH-1:0] query_idx   [2];
    logic                 query_ready [2];
    logic [31:0]          query_val   [2];

    assign query_idx[0] = query1Index;
    assign query_idx[1] = query2Index;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_query
            logic        rdy;
            logic [31:0] val;

            always_comb begin
                rdy = 1'b0;
                val = entry_val[query_idx[gi]];
                if (entry_valid[query_idx[gi]]) begin
                    if (rsUpdate && (rsRobIndex == query_idx[gi])) begin
                        rdy = 1'b1;
                        val = rsVal;
                    end else if (lsbUpdate && (lsbRobIndex == query_idx[gi])) begin
                        rdy = 1'b1;
                        val = lsbVal;
                    end else begin
                        rdy = entry_ready[query_idx[gi]];
                    end
                end
            end

            assign query_ready[gi] = rdy;
            assign query_val[gi]   = val;
        end
    endgenerate

    assign query1Ready = query_ready[0];
    assign query2Ready = query_ready[1];
    assign query1Val   = query_val[0];
    assign query2Val   = query_val[1];

    // ------------------------------------------------------------------------
    // Registered retirement outputs. Pulses last one cycle; the data fields
    // hold their last value between commits.
    // ------------------------------------------------------------------------
    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            commit_valid_q <= 1'b0;
            commit_idx_q   <= '0;
            commit_rd_q    <= '0;
            commit_val_q   <= '0;
            commit_write_q <= 1'b0;
            commit_store_q <= 1'b0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
            halt_q         <= 1'b0;
        end else begin
            commit_valid_q <= commit_fire;
            commit_write_q <= commit_fire && (head_type == TYPE_REG);
            commit_store_q <= commit_fire && (head_type == TYPE_STORE);
            flush_q        <= mispredict;
            if (commit_fire) begin
                commit_idx_q <= head_q;
                commit_rd_q  <= entry_rd[head_q];
                commit_val_q <= head_val;
            end
            if (mispredict) begin
                flush_pc_q <= entry_alt[head_q];
            end
            if (commit_fire && (head_type == TYPE_HALT)) begin
                halt_q <= 1'b1;
            end
        end
    end

    assign commitValid    = commit_valid_q;
    assign commitRobIndex = commit_idx_q;
    assign commitRd       = commit_rd_q;
    assign commitVal      = commit_val_q;
    assign commitWrite    = commit_write_q;
    assign commitStore    = commit_store_q;
    assign flush          = flush_q;
    assign flushPc        = flush_pc_q;
    assign halt           = halt_q;

`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_commits_q, perf_commits_d;
    logic [31:0] perf_flushes_q, perf_flushes_d;

    // Counted from the registered pulses so the counts track what consumers saw.
    assign perf_commits_d = perf_commits_q + {31'd0, commit_valid_q};
    assign perf_flushes_d = perf_flushes_q + {31'd0, flush_q};

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            perf_commits_q <= '0;
            perf_flushes_q <= '0;
        end else begin
            perf_commits_q <= perf_commits_d;
            perf_flushes_q <= perf_flushes_d;
        end
    end

    assign perfCommits = perf_commits_q;
    assign perfFlushes = perf_flushes_q;
`endif

endmodule
